fc84_stream_packer: RTL and testbench

Sequential front/back end for the 84-input fully connected neuron. It accepts a valid/ready stream of (activation, weight) pairs, one pair per beat, and packs them into the flat 84-lane activation and weight buses the combinational neuron consumes, together with the bias. It then captures the neuron's sum into a register and presents it on a valid/ready result port. One instance sits between the layer sequencer, which streams F6 inputs and weights, and each fc_84 neuron.

---
 rtl/fc84_stream_packer_if.sv | 18 +
 rtl/fc84_stream_packer.sv | 51 +++++
 tb/tb_fc84_stream_packer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/fc84_stream_packer_if.sv
// fc84_stream_packer_if: beat stream, neuron buses and result port of the packer
interface fc84_stream_packer_if #(
  parameter int BIT_WIDTH = 32,
  parameter int OUT_WIDTH = 64
);
  logic s_valid, s_ready, s_last, m_valid, m_ready, frame_err;
  logic [BIT_WIDTH-1:0] s_act, s_weight, s_bias, fc_bias;
  logic [BIT_WIDTH*84-1:0] fc_in, fc_weights;
  logic [OUT_WIDTH-1:0] fc_out, m_data;
  modport master (
    output s_valid, s_act, s_weight, s_bias, s_last, fc_out, m_ready,
    input  s_ready, fc_in, fc_weights, fc_bias, m_valid, m_data, frame_err
  );
  modport slave (
    input  s_valid, s_act, s_weight, s_bias, s_last, fc_out, m_ready,
    output s_ready, fc_in, fc_weights, fc_bias, m_valid, m_data, frame_err
  );
endinterface

// File: rtl/fc84_stream_packer.sv
// fc84_stream_packer: packs 84 streamed (act, weight) beats for the neuron and returns its captured sum
module fc84_stream_packer #(
  parameter int BIT_WIDTH = 32,
  parameter int OUT_WIDTH = 64
) (
  input logic clk,
  input logic rst,
  fc84_stream_packer_if.slave bus
);
  typedef enum logic [1:0] {LOAD, CALC, OUT} state_t;
  state_t state;
  logic [6:0] cnt;
  logic [BIT_WIDTH*84-1:0] act_q, wt_q;
  logic [BIT_WIDTH-1:0] bias_q;
  logic [OUT_WIDTH-1:0] data_q;
  logic err_q, accept, at_end;
  assign accept = bus.s_valid && state == LOAD;
  assign at_end = cnt == 7'd83;
  assign bus.s_ready = state == LOAD;
  assign bus.m_valid = state == OUT;
  assign bus.fc_in = act_q;
  assign bus.fc_weights = wt_q;
  assign bus.fc_bias = bias_q;
  assign bus.m_data = data_q;
  assign bus.frame_err = err_q;
  // the lane counter alone closes a frame; s_last only feeds the sticky error flag
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= LOAD;
      cnt <= '0;
      act_q <= '0;
      wt_q <= '0;
      bias_q <= '0;
      data_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (accept) begin
        act_q[BIT_WIDTH*cnt +: BIT_WIDTH] <= bus.s_act;
        wt_q[BIT_WIDTH*cnt +: BIT_WIDTH] <= bus.s_weight;
        if (cnt == 7'd0) bias_q <= bus.s_bias;
        if (bus.s_last != at_end) err_q <= 1'b1;
        cnt <= at_end ? 7'd0 : cnt + 7'd1;
        if (at_end) state <= CALC;
      end
      if (state == CALC) begin
        data_q <= bus.fc_out;
        state <= OUT;
      end
      if (state == OUT && bus.m_ready) state <= LOAD;
    end
endmodule

// File: tb/tb_fc84_stream_packer.sv
// tb_fc84_stream_packer: randomized frames against a lane-array reference model with a result scoreboard
module tb_fc84_stream_packer;
  localparam int BW = 32, OW = 64;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  fc84_stream_packer_if #(.BIT_WIDTH(BW), .OUT_WIDTH(OW)) bus();
  fc84_stream_packer #(.BIT_WIDTH(BW), .OUT_WIDTH(OW)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0, errors = 0, cyc = 0, first_cyc = 0, m_cnt = 0;
  longint exp_q[$];
  logic [31:0] m_act[84], m_wt[84], m_bias;
  bit m_err = 0, mode_dot = 0;
  longint const_out = -10;
  always @(posedge clk) cyc++;
  // stub neuron: either a fixed sum or the true dot product of whatever the packer presents
  always_comb begin
    longint s;
    s = longint'($signed(bus.fc_bias));
    for (int i = 0; i < 84; i++)
      s += longint'($signed(bus.fc_in[i*BW +: BW])) * longint'($signed(bus.fc_weights[i*BW +: BW]));
    bus.fc_out = mode_dot ? s : const_out;
  end
  task automatic chk(string name, logic [63:0] got, logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask
  function automatic longint model_sum();
    longint s = longint'($signed(m_bias));
    for (int i = 0; i < 84; i++) s += longint'($signed(m_act[i])) * longint'($signed(m_wt[i]));
    return s;
  endfunction
  always @(negedge clk)
    if (!rst && bus.m_valid && bus.m_ready) begin
      chk("result_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) chk("m_data", bus.m_data, exp_q.pop_front());
    end
  task automatic beat(logic [31:0] a, logic [31:0] w, logic [31:0] b, bit last, int gap_max);
    int n = 0;
    bit ok;
    repeat ($urandom_range(gap_max, 0)) begin
      bus.s_valid = 1'b0;
      @(posedge clk); #1;
    end
    bus.s_valid = 1'b1; bus.s_act = a; bus.s_weight = w; bus.s_bias = b; bus.s_last = last;
    do begin
      ok = bus.s_ready;
      @(posedge clk); #1;
      n++;
    end while (!ok && n < 1000);
    bus.s_valid = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL beat_timeout got no s_ready want acceptance within 1000 cycles");
      return;
    end
    m_act[m_cnt] = a;
    m_wt[m_cnt] = w;
    if (m_cnt == 0) begin
      m_bias = b;
      first_cyc = cyc;
    end
    m_err |= (last != (m_cnt == 83));
    chk("frame_err", 64'(bus.frame_err), 64'(m_err));
    if (m_cnt == 83) begin
      exp_q.push_back(mode_dot ? model_sum() : const_out);
      m_cnt = 0;
    end else m_cnt++;
  endtask
  task automatic frame(bit directed, int gap_max, bit bad, int beats = 84);
    for (int k = 0; k < beats; k++)
      beat(directed ? 32'(k + 1) : $urandom, directed ? 32'(-(k + 1)) : $urandom,
           directed ? 32'd7 : $urandom, bad ? (k == 40) : (k == 83), gap_max);
  endtask
  task automatic check_lanes();
    for (int i = 0; i < 84; i++) begin
      chk($sformatf("lane_act%0d", i), 64'(bus.fc_in[i*BW +: BW]), 64'(m_act[i]));
      chk($sformatf("lane_wt%0d", i), 64'(bus.fc_weights[i*BW +: BW]), 64'(m_wt[i]));
    end
    chk("fc_bias", 64'(bus.fc_bias), 64'(m_bias));
  endtask
  task automatic check_reset_values();
    chk("rst_s_ready", 64'(bus.s_ready), 64'd1);
    chk("rst_m_valid", 64'(bus.m_valid), 64'd0);
    chk("rst_m_data", bus.m_data, 64'd0);
    chk("rst_frame_err", 64'(bus.frame_err), 64'd0);
    chk("rst_fc_in", 64'(bus.fc_in != '0), 64'd0);
    chk("rst_fc_weights", 64'(bus.fc_weights != '0), 64'd0);
    chk("rst_fc_bias", 64'(bus.fc_bias), 64'd0);
  endtask
  task automatic model_reset();
    for (int i = 0; i < 84; i++) begin
      m_act[i] = '0;
      m_wt[i] = '0;
    end
    m_bias = '0; m_cnt = 0; m_err = 0;
    exp_q.delete();
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog got no finish want finish before 2ms");
    $fatal(1);
  end
  initial begin
    int a0, n;
    logic [63:0] hold;
    bus.s_valid = 1'b0; bus.s_act = '0; bus.s_weight = '0; bus.s_bias = '0; bus.s_last = 1'b0;
    bus.m_ready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_reset_values();
    rst = 1'b0;
    // directed packing frame with fixed -10 neuron, latency and handshake timing
    frame(1, 0, 0);
    chk("calc_m_valid", 64'(bus.m_valid), 64'd0);
    chk("calc_s_ready", 64'(bus.s_ready), 64'd0);
    @(posedge clk); #1;
    chk("out_m_valid", 64'(bus.m_valid), 64'd1);
    chk("out_m_data", bus.m_data, 64'hFFFF_FFFF_FFFF_FFF6);
    check_lanes();
    @(posedge clk); #1;
    chk("load_s_ready", 64'(bus.s_ready), 64'd1);
    chk("load_m_valid", 64'(bus.m_valid), 64'd0);
    a0 = first_cyc;
    mode_dot = 1;
    frame(0, 0, 0);
    chk("frame_period", 64'(first_cyc - a0), 64'd86);
    frame(0, 3, 0);
    // result stall with the next frame already pushing beats
    bus.m_ready = 1'b0;
    fork
      frame(0, 2, 0);
      begin
        @(posedge clk); #1;
        hold = bus.m_data;
        repeat (10) begin
          chk("stall_m_valid", 64'(bus.m_valid), 64'd1);
          chk("stall_s_ready", 64'(bus.s_ready), 64'd0);
          chk("stall_m_data", bus.m_data, hold);
          @(posedge clk); #1;
        end
        bus.m_ready = 1'b1;
      end
    join
    frame(0, 1, 1);
    frame(0, 1, 0);
    frame(0, 1, 0, 50);
    @(posedge clk); #3;
    rst = 1'b1;
    #1 check_reset_values();
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    frame(0, 1, 0);
    check_lanes();
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("results_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
